fetch_seq: RTL and testbench

//  Multi-cycle instruction fetch sequencer: producer side of the control-decoder interface.

---
 rtl/fetch_seq_if.sv | 26 ++
 rtl/fetch_seq.sv | 109 ++++++++++
 tb/tb_fetch_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_if.sv
// Fetch-sequencer bundle: instruction-memory req/rvalid handshake plus the
// decoder-facing instruction, PC and retire/branch-outcome signals.
interface fetch_seq_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic        retire;
   logic        pcsrc;
   logic        jmp;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, op, funct, pc,
      input  imem_rvalid, imem_rdata, retire, pcsrc, jmp
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, op, funct, pc,
      output imem_rvalid, imem_rdata, retire, pcsrc, jmp
   );
endinterface

// File: rtl/fetch_seq.sv
// Multi-cycle instruction fetch sequencer: requests words from imem, presents
// them to the decoder and forms the next PC from branch/jump outcomes at retire.
//
// state   | meaning
// S_IDLE  | first cycle after reset, goes straight to S_REQ
// S_REQ   | one-cycle imem_req pulse at imem_addr = pc
// S_WAIT  | waiting for imem_rvalid; retries the same pc after WAIT_TIMEOUT cycles
// S_ISSUE | instruction presented; waits for retire to advance pc
module fetch_seq #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          WAIT_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   fetch_seq_if.master bus,
   output logic        fetch_err,
   output logic [31:0] instr_count
);

   localparam int            CW       = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ISSUE} state_t;

   state_t        state;
   logic [31:0]   pc_q;
   logic          req_q;
   logic [31:0]   addr_q;
   logic          vld_q;
   logic [31:0]   instr_q;
   logic [CW-1:0] cnt_q;

   logic [31:0] pc_plus4;
   logic [31:0] br_off;
   logic [31:0] next_pc;

   assign pc_plus4 = pc_q + 32'd4;
   assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   // jmp takes priority over a simultaneous taken branch
   always_comb begin
      next_pc = pc_plus4;
      if (bus.jmp)
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      else if (bus.pcsrc)
         next_pc = pc_plus4 + br_off;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         pc_q        <= RESET_PC;
         req_q       <= 1'b0;
         addr_q      <= RESET_PC;
         vld_q       <= 1'b0;
         instr_q     <= '0;
         cnt_q       <= '0;
         fetch_err   <= 1'b0;
         instr_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               state  <= S_REQ;
               req_q  <= 1'b1;
               addr_q <= pc_q;
            end
            S_REQ: begin
               state <= S_WAIT;
               req_q <= 1'b0;
               cnt_q <= '0;
            end
            S_WAIT: begin
               if (bus.imem_rvalid) begin
                  instr_q <= bus.imem_rdata;
                  vld_q   <= 1'b1;
                  state   <= S_ISSUE;
               end else if (cnt_q == CNT_LAST) begin
                  fetch_err <= 1'b1;
                  req_q     <= 1'b1;
                  addr_q    <= pc_q;
                  state     <= S_REQ;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_ISSUE: begin
               if (bus.retire) begin
                  pc_q        <= next_pc;
                  addr_q      <= next_pc;
                  req_q       <= 1'b1;
                  vld_q       <= 1'b0;
                  instr_count <= instr_count + 32'd1;
                  state       <= S_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = addr_q;
   assign bus.instr_valid = vld_q;
   assign bus.instr       = instr_q;
   assign bus.op          = instr_q[31:26];
   assign bus.funct       = instr_q[5:0];
   assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed vector table, timeout/reset
// sequences and randomized instructions against a next-PC reference model.
module tb_fetch_seq;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_err;
   logic [31:0] instr_count;

   fetch_seq_if bus ();

   fetch_seq #(.RESET_PC(32'h0000_0000), .WAIT_TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .fetch_err   (fetch_err),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          fails  = 0;
   logic [31:0] pc_m;
   logic [31:0] cnt_m;
   logic        err_m;

   typedef struct {
      logic [31:0] ir;
      int          delay;
      int          hold;
      logic        br;
      logic        j;
      logic        noise;
      logic [31:0] next;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // architectural next-PC rule, in plain integer arithmetic
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ir,
                                            input logic br, input logic j);
      logic [31:0] seq;
      longint      off;
      seq = pc + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
      if (br) begin
         off = longint'($signed(ir[15:0])) * 4;
         return 32'(longint'(seq) + off);
      end
      return seq;
   endfunction

   task automatic chk_reset(input string name);
      chk({name, " imem_req"},    32'(bus.imem_req), 32'd0);
      chk({name, " imem_addr"},   bus.imem_addr, 32'h0);
      chk({name, " instr_valid"}, 32'(bus.instr_valid), 32'd0);
      chk({name, " instr"},       bus.instr, 32'h0);
      chk({name, " pc"},          bus.pc, 32'h0);
      chk({name, " fetch_err"},   32'(fetch_err), 32'd0);
      chk({name, " instr_count"}, instr_count, 32'd0);
   endtask

   task automatic wait_idle_drive(input logic noise);
      bus.imem_rvalid = 1'b0;
      if (noise) begin
         bus.retire = 1'($urandom);
         bus.pcsrc  = 1'($urandom);
         bus.jmp    = 1'($urandom);
      end
   endtask

   task automatic wait_req(input string name);
      int i;
      i = 0;
      while (bus.imem_req !== 1'b1 && i < 40) begin
         @(negedge clk);
         i++;
      end
      chk({name, " req seen"}, 32'(bus.imem_req), 32'd1);
      chk({name, " req addr"}, bus.imem_addr, pc_m);
      @(negedge clk);
      chk({name, " req pulse"}, 32'(bus.imem_req), 32'd0);
   endtask

   task automatic run_instr(input string name, input logic [31:0] ir, input int delay,
                            input int hold, input int timeouts, input logic br,
                            input logic j, input logic noise, input logic [31:0] exp_next);
      wait_req(name);
      for (int t = 0; t < timeouts; t++) begin
         repeat (TMO) begin
            wait_idle_drive(noise);
            @(negedge clk);
         end
         err_m = 1'b1;
         chk({name, " retry req"}, 32'(bus.imem_req), 32'd1);
         chk({name, " fetch_err"}, 32'(fetch_err), 32'(err_m));
         wait_req(name);
      end
      repeat (delay - 1) begin
         wait_idle_drive(noise);
         @(negedge clk);
      end
      bus.retire      = 1'b0;
      bus.pcsrc       = 1'b0;
      bus.jmp         = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = ir;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      chk({name, " instr_valid"}, 32'(bus.instr_valid), 32'd1);
      chk({name, " instr"},       bus.instr, ir);
      chk({name, " op"},          32'(bus.op), ir >> 26);
      chk({name, " funct"},       32'(bus.funct), ir & 32'h3F);
      chk({name, " pc"},          bus.pc, pc_m);
      chk({name, " fetch_err"},   32'(fetch_err), 32'(err_m));
      repeat (hold) begin
         if (noise) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = $urandom;
         end
         @(negedge clk);
      end
      bus.imem_rvalid = 1'b0;
      chk({name, " instr hold"}, bus.instr, ir);
      bus.retire = 1'b1;
      bus.pcsrc  = br;
      bus.jmp    = j;
      @(negedge clk);
      bus.retire = 1'b0;
      bus.pcsrc  = 1'b0;
      bus.jmp    = 1'b0;
      pc_m  = exp_next;
      cnt_m = cnt_m + 32'd1;
      chk({name, " next req"},    32'(bus.imem_req), 32'd1);
      chk({name, " next addr"},   bus.imem_addr, exp_next);
      chk({name, " count"},       instr_count, cnt_m);
      chk({name, " valid drop"},  32'(bus.instr_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ir;
      logic        br, j;

      tbl[0]  = '{32'h2008_0005, 2,  0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
      tbl[1]  = '{32'h0000_0020, 1,  1, 1'b0, 1'b0, 1'b1, 32'h0000_0008};
      tbl[2]  = '{32'h1000_FFFE, 3,  0, 1'b1, 1'b0, 1'b0, 32'h0000_0004};
      tbl[3]  = '{32'h1000_FFFE, 1,  2, 1'b0, 1'b0, 1'b1, 32'h0000_0008};
      tbl[4]  = '{32'h1000_FFFE, 16, 0, 1'b0, 1'b0, 1'b0, 32'h0000_000C};
      tbl[5]  = '{32'h1000_8000, 4,  1, 1'b1, 1'b0, 1'b1, 32'hFFFE_0010};
      tbl[6]  = '{32'h0800_0040, 2,  0, 1'b1, 1'b1, 1'b0, 32'hF000_0100};
      tbl[7]  = '{32'h0BFF_FFFF, 5,  3, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC};
      tbl[8]  = '{32'h0000_0000, 1,  0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
      tbl[9]  = '{32'h1000_7FFF, 2,  0, 1'b1, 1'b0, 1'b0, 32'h0002_0000};
      tbl[10] = '{32'h0800_0040, 3,  1, 1'b1, 1'b1, 1'b1, 32'h0000_0100};

      rst             = 1'b1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.retire      = 1'b0;
      bus.pcsrc       = 1'b0;
      bus.jmp         = 1'b0;
      pc_m  = 32'h0;
      cnt_m = 32'h0;
      err_m = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      foreach (tbl[k])
         run_instr($sformatf("vec%0d", k), tbl[k].ir, tbl[k].delay, tbl[k].hold, 0,
                   tbl[k].br, tbl[k].j, tbl[k].noise, tbl[k].next);

      // timeout with retry at the same pc, then rvalid on the last allowed WAIT cycle
      chk("pre-timeout fetch_err", 32'(fetch_err), 32'd0);
      run_instr("timeout", 32'h0000_0020, TMO, 1, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0104);
      run_instr("after timeout", 32'h0000_0020, 1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0108);

      // reset in WAIT at pc 0x20, stale rvalid right after release
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      pc_m  = 32'h0;
      cnt_m = 32'h0;
      err_m = 1'b0;
      run_instr("to 0x20", 32'h1000_0007, 1, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0020);
      wait_req("pre rst");
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset("mid rst");
      @(negedge clk);
      rst             = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      pc_m  = 32'h0;
      cnt_m = 32'h0;
      @(negedge clk);
      chk("stale rvalid valid", 32'(bus.instr_valid), 32'd0);
      chk("stale rvalid instr", bus.instr, 32'h0);
      run_instr("post rst", 32'h2008_0005, 3, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

      for (int n = 0; n < 150; n++) begin
         ir = $urandom;
         br = 1'($urandom);
         j  = 1'($urandom_range(0, 3) == 0);
         run_instr($sformatf("rnd%0d", n), ir, int'($urandom_range(1, TMO)),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0) ? 1 : 0,
                   br, j, 1'($urandom), ref_next(pc_m, ir, br, j));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
